// File: rtl/acker_sensor_arbiter_pkg.sv
// rtl/acker_sensor_arbiter_pkg.sv - shared state codes, widths and sensor type codes
package acker_sensor_arbiter_pkg;

    localparam int ACKER_DATA_W = 14;
    localparam int ACKER_NUM_CH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    localparam logic [1:0] SENSOR_TYPE_0 = 2'b00;
    localparam logic [1:0] SENSOR_TYPE_1 = 2'b01;
    localparam logic [1:0] SENSOR_TYPE_2 = 2'b10;
    localparam logic [1:0] SENSOR_TYPE_3 = 2'b11;

    function automatic logic [1:0] rr_offset(input logic [1:0] base, input logic [2:0] k);
        return base + k[1:0];
    endfunction

endpackage

// File: rtl/acker_sensor_arbiter_if.sv
// rtl/acker_sensor_arbiter_if.sv - handshake bundle between the arbiter and data_access
interface acker_sensor_arbiter_if
    import acker_sensor_arbiter_pkg::*;
#(
    parameter int DATA_W = ACKER_DATA_W
) ();
    logic [DATA_W-1:0] da_Data_in;
    logic              da_Data_in_valid;
    logic [1:0]        da_sensor_type;
    logic              da_Ready_for_Data_in;

    modport master (
        output da_Data_in,
        output da_Data_in_valid,
        output da_sensor_type,
        input  da_Ready_for_Data_in
    );

    modport slave (
        input  da_Data_in,
        input  da_Data_in_valid,
        input  da_sensor_type,
        output da_Ready_for_Data_in
    );
endinterface

// File: rtl/acker_sensor_arbiter_rr_pick.sv
// rtl/acker_sensor_arbiter_rr_pick.sv - combinational 4-way round-robin picker
module acker_rr_pick
    import acker_sensor_arbiter_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] gnt_idx,
    output logic       any
);
    logic [1:0] idx;

    // Search begins just after the previous winner so every channel gets a turn.
    always_comb begin
        gnt_idx = 2'd0;
        any     = 1'b0;
        idx     = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = rr_offset(last, 3'(k));
            if (!any && req[idx]) begin
                gnt_idx = idx;
                any     = 1'b1;
            end
        end
    end
endmodule

// File: rtl/acker_sensor_arbiter.sv
// rtl/acker_sensor_arbiter.sv - buffers one sample per sensor channel and issues them round-robin to data_access
module acker_sensor_arbiter
    import acker_sensor_arbiter_pkg::*;
#(
    parameter int                   NUM_CH    = ACKER_NUM_CH,
    parameter int                   DATA_W    = ACKER_DATA_W,
    parameter int                   TIMEOUT_W = 16,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT   = 16'd50000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [NUM_CH-1:0]        ch_enable,
    input  logic                     overrun_clear,
    acker_sensor_arbiter_if.master   da,
    output logic [NUM_CH-1:0]        pending,
    output logic [NUM_CH-1:0]        overrun,
    output logic                     timeout_err
);
    state_t               state, state_next;
    logic [DATA_W-1:0]    buf_data [NUM_CH];
    logic [NUM_CH-1:0]    full;
    logic [NUM_CH-1:0]    load;
    logic [NUM_CH-1:0]    granted;
    logic [NUM_CH-1:0]    ovr_set;
    logic [1:0]           last_grant;
    logic [1:0]           win;
    logic                 any_req;
    logic                 grant;
    logic                 valid_next;
    logic                 timeout_set;
    logic [TIMEOUT_W-1:0] wd, wd_next;

    acker_rr_pick u_pick (
        .req     (full),
        .last    (last_grant),
        .gnt_idx (win),
        .any     (any_req)
    );

    assign pending = full;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        grant       = 1'b0;
        valid_next  = 1'b0;
        wd_next     = wd;
        timeout_set = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_req && da.da_Ready_for_Data_in) begin
                    grant      = 1'b1;
                    valid_next = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            // Ready seen here is still the stale high from before the issue.
            ST_ISSUE: begin
                wd_next    = TIMEOUT;
                state_next = ST_BUSY;
            end
            ST_BUSY: begin
                if (da.da_Ready_for_Data_in) begin
                    wd_next    = '0;
                    state_next = ST_IDLE;
                end else if (wd <= TIMEOUT_W'(1)) begin
                    wd_next     = '0;
                    timeout_set = 1'b1;
                    state_next  = ST_IDLE;
                end else begin
                    wd_next = wd - TIMEOUT_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A grant frees its entry, so a sample landing in the grant cycle is a refill, not an overrun.
    always_comb begin
        load    = '0;
        granted = '0;
        ovr_set = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            load[i]    = ch_valid[i] & ch_enable[i];
            granted[i] = grant && (win == 2'(i));
            ovr_set[i] = load[i] & full[i] & ~granted[i];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            full                <= '0;
            overrun             <= '0;
            timeout_err         <= 1'b0;
            last_grant          <= 2'd3;
            wd                  <= '0;
            da.da_Data_in       <= '0;
            da.da_Data_in_valid <= 1'b0;
            da.da_sensor_type   <= 2'd0;
            for (int i = 0; i < NUM_CH; i++) begin
                buf_data[i] <= '0;
            end
        end else begin
            wd                  <= wd_next;
            da.da_Data_in_valid <= valid_next;
            if (grant) begin
                da.da_Data_in     <= buf_data[win];
                da.da_sensor_type <= win;
                last_grant        <= win;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                full[i] <= load[i] | (full[i] & ~granted[i]);
                if (load[i]) begin
                    buf_data[i] <= ch_data[i*DATA_W +: DATA_W];
                end
            end
            overrun     <= (overrun & ~{NUM_CH{overrun_clear}}) | ovr_set;
            timeout_err <= (timeout_err & ~overrun_clear) | timeout_set;
        end
    end
endmodule

// File: tb/tb_acker_sensor_arbiter.sv
// tb/tb_acker_sensor_arbiter.sv - self-checking bench for acker_sensor_arbiter
module tb_acker_sensor_arbiter;
    localparam int TO = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  ch_valid = 4'h0;
    logic [55:0] ch_data = '0;
    logic [3:0]  ch_enable = 4'hF;
    logic        overrun_clear = 1'b0;
    logic        ready = 1'b0;
    logic [3:0]  pending;
    logic [3:0]  overrun;
    logic        timeout_err;

    int vectors = 0;
    int errors  = 0;

    acker_sensor_arbiter_if #(.DATA_W(14)) da_bus ();
    assign da_bus.da_Ready_for_Data_in = ready;

    acker_sensor_arbiter #(.TIMEOUT(16'd8)) dut (
        .clock         (clock),
        .reset         (reset),
        .ch_valid      (ch_valid),
        .ch_data       (ch_data),
        .ch_enable     (ch_enable),
        .overrun_clear (overrun_clear),
        .da            (da_bus.master),
        .pending       (pending),
        .overrun       (overrun),
        .timeout_err   (timeout_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: pending samples, transfer phase and time spent waiting.
    bit         m_known = 0;
    bit   [3:0] m_full, m_ovr;
    int         m_buf [4];
    int         m_last, m_phase, m_cnt, m_data, m_type, m_g;
    bit         m_valid, m_terr;

    always @(posedge clock) begin
        if (!reset) begin
            m_known = 1; m_full = 0; m_ovr = 0; m_last = 3; m_phase = 0; m_cnt = 0;
            m_data = 0; m_type = 0; m_valid = 0; m_terr = 0;
            for (int i = 0; i < 4; i++) m_buf[i] = 0;
        end else if (m_known) begin
            m_g = -1;
            if (m_phase == 0 && m_full != 0 && ready)
                for (int k = 1; k <= 4; k++)
                    if (m_g < 0 && m_full[(m_last + k) % 4]) m_g = (m_last + k) % 4;
            m_valid = (m_g >= 0);
            if (overrun_clear) begin m_ovr = 0; m_terr = 0; end
            if (m_phase == 0) begin
                if (m_g >= 0) begin
                    m_phase = 1; m_data = m_buf[m_g]; m_type = m_g; m_last = m_g;
                end
            end else if (m_phase == 1) begin
                m_phase = 2; m_cnt = 0;
            end else begin
                m_cnt++;
                if (ready) m_phase = 0;
                else if (m_cnt >= TO) begin m_terr = 1; m_phase = 0; end
            end
            for (int i = 0; i < 4; i++) begin
                if (ch_valid[i] && ch_enable[i]) begin
                    if (m_full[i] && m_g != i) m_ovr[i] = 1;
                    m_full[i] = 1;
                    m_buf[i] = int'(ch_data[14*i +: 14]);
                end else if (m_g == i) begin
                    m_full[i] = 0;
                end
            end
        end
    end

    int  log_q [$];
    int  exp_q [$];
    bit  prev_valid = 0;

    always @(posedge clock) begin
        #2;
        if (m_known) begin
            check("valid", 32'(da_bus.da_Data_in_valid), 32'(m_valid));
            check("data", 32'(da_bus.da_Data_in), m_data);
            check("type", 32'(da_bus.da_sensor_type), m_type);
            check("pending", 32'(pending), 32'(m_full));
            check("overrun", 32'(overrun), 32'(m_ovr));
            check("timeout_err", 32'(timeout_err), 32'(m_terr));
            if (da_bus.da_Data_in_valid) begin
                check("valid_spacing", 32'(prev_valid), 32'd0);
                log_q.push_back(int'(da_bus.da_sensor_type) * 65536 + int'(da_bus.da_Data_in));
            end
            prev_valid = da_bus.da_Data_in_valid;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic strobe(input int ch, input logic [13:0] d);
        ch_valid[ch] = 1'b1;
        ch_data[14*ch +: 14] = d;
        tick(1);
        ch_valid = 4'h0;
    endtask

    task automatic check_log(input string name);
        check({name, "_len"}, 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
            check({name, "_entry"}, 32'(log_q[i]), 32'(exp_q[i]));
        log_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_valid"}, 32'(da_bus.da_Data_in_valid), 32'd0);
        check({name, "_data"}, 32'(da_bus.da_Data_in), 32'd0);
        check({name, "_type"}, 32'(da_bus.da_sensor_type), 32'd0);
        check({name, "_pending"}, 32'(pending), 32'd0);
        check({name, "_overrun"}, 32'(overrun), 32'd0);
        check({name, "_terr"}, 32'(timeout_err), 32'd0);
    endtask

    initial begin
        tick(3);
        check_reset_state("reset");
        reset = 1'b1;
        tick(1);

        // Single sample, one-cycle latency after the load edge.
        ready = 1'b1;
        log_q.delete();
        strobe(2, 14'h2ABC);
        check("single_pending", 32'(pending), 32'h4);
        tick(1);
        check("single_valid", 32'(da_bus.da_Data_in_valid), 32'd1);
        check("single_data", 32'(da_bus.da_Data_in), 32'h2ABC);
        check("single_type", 32'(da_bus.da_sensor_type), 32'd2);
        check("single_pending_clr", 32'(pending), 32'h0);
        tick(1);
        check("single_valid_drop", 32'(da_bus.da_Data_in_valid), 32'd0);
        tick(3);
        exp_q.push_back(2 * 65536 + 32'h2ABC);
        check_log("single_log");

        // Fairness across two full rounds.
        reset = 1'b0; ready = 1'b0;
        tick(2);
        reset = 1'b1;
        log_q.delete();
        ch_data = {14'h3333, 14'h2222, 14'h1111, 14'h0AAA};
        ch_valid = 4'hF;
        tick(1);
        ch_valid = 4'h0;
        check("fair_pending", 32'(pending), 32'hF);
        ready = 1'b1;
        tick(16);
        ch_data = {14'h3003, 14'h2002, 14'h1001, 14'h0004};
        ch_valid = 4'hF;
        tick(1);
        ch_valid = 4'h0;
        tick(16);
        exp_q = '{32'h0AAA, 65536 + 32'h1111, 2 * 65536 + 32'h2222, 3 * 65536 + 32'h3333,
                  32'h0004, 65536 + 32'h1001, 2 * 65536 + 32'h2002, 3 * 65536 + 32'h3003};
        check_log("fair_log");

        // Overrun while data_access is not ready.
        ready = 1'b0;
        strobe(1, 14'h0001);
        strobe(1, 14'h0002);
        check("ovr_set", 32'(overrun), 32'h2);
        check("ovr_pending", 32'(pending), 32'h2);
        ready = 1'b1;
        tick(6);
        exp_q.push_back(65536 + 2);
        check_log("ovr_log");
        check("ovr_sticky", 32'(overrun), 32'h2);
        overrun_clear = 1'b1;
        tick(1);
        overrun_clear = 1'b0;
        check("ovr_cleared", 32'(overrun), 32'h0);

        // Refill in the grant cycle, data frozen through BUSY.
        ch_valid[0] = 1'b1;
        ch_data[13:0] = 14'h0AAA;
        tick(1);
        ch_data[13:0] = 14'h0123;
        tick(1);
        ch_valid = 4'h0;
        ch_data[13:0] = 14'h3FFF;
        ready = 1'b0;
        check("refill_valid", 32'(da_bus.da_Data_in_valid), 32'd1);
        check("refill_data", 32'(da_bus.da_Data_in), 32'h0AAA);
        check("refill_pending", 32'(pending), 32'h1);
        check("refill_no_ovr", 32'(overrun), 32'h0);
        tick(3);
        check("frozen_data", 32'(da_bus.da_Data_in), 32'h0AAA);
        check("frozen_type", 32'(da_bus.da_sensor_type), 32'd0);
        ready = 1'b1;
        tick(6);
        exp_q = '{32'h0AAA, 32'h0123};
        check_log("refill_log");

        // Watchdog: ready withheld after the issue.
        strobe(3, 14'h3FFF);
        tick(1);
        check("wd_issue", 32'(da_bus.da_Data_in_valid), 32'd1);
        ready = 1'b0;
        tick(8);
        check("wd_not_yet", 32'(timeout_err), 32'd0);
        tick(1);
        check("wd_fired", 32'(timeout_err), 32'd1);
        overrun_clear = 1'b1;
        tick(1);
        overrun_clear = 1'b0;
        check("wd_cleared", 32'(timeout_err), 32'd0);
        ready = 1'b1;
        tick(2);
        log_q.delete();

        // Reset while BUSY drops buffered samples.
        ch_data[27:14] = 14'h1555;
        ch_data[41:28] = 14'h2666;
        ch_valid = 4'b0110;
        tick(1);
        ch_valid = 4'h0;
        tick(1);
        check("rst_busy_type", 32'(da_bus.da_sensor_type), 32'd1);
        ready = 1'b0;
        tick(2);
        check("rst_busy_pending", 32'(pending), 32'h4);
        log_q.delete();
        reset = 1'b0;
        tick(1);
        check_reset_state("midreset");
        reset = 1'b1;
        ready = 1'b1;
        tick(6);
        check_log("midreset_log");

        // Disabled channel ignores its strobe.
        ch_enable = 4'b1110;
        strobe(0, 14'h0777);
        check("enable_pending", 32'(pending), 32'h0);
        tick(5);
        check_log("enable_log");
        ch_enable = 4'hF;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
